// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator CPU sequencer.
package cpu_pkg;

    // Sequencer states; the encoding is visible on o_state for debug.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_INDIRECT = 4'd3,
        ST_EXEC_RD  = 4'd4,
        ST_EXEC_OP  = 4'd5,
        ST_EXEC_WR  = 4'd6,
        ST_EXEC_REG = 4'd7,
        ST_INTR     = 4'd8,
        ST_HALT     = 4'd9
    } state_e;

    // Operation codes presented to the accumulator/E datapath.
    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_AND = 4'd1,
        OP_ADD = 4'd2,
        OP_LDA = 4'd3,
        OP_CLA = 4'd4,
        OP_CLE = 4'd5,
        OP_CMA = 4'd6,
        OP_CME = 4'd7,
        OP_CIR = 4'd8,
        OP_CIL = 4'd9,
        OP_INC = 4'd10
    } op_code_e;

    // Conditional skips of the register-reference group.
    typedef enum logic [2:0] {
        SKIP_NONE = 3'd0,
        SKIP_SPA  = 3'd1,
        SKIP_SNA  = 3'd2,
        SKIP_SZA  = 3'd3,
        SKIP_SZE  = 3'd4
    } skip_e;

    // Memory-reference opcodes (ir[DWIDTH-2:DWIDTH-4]); 7 selects reg/IO.
    localparam logic [2:0] MOP_AND = 3'd0;
    localparam logic [2:0] MOP_ADD = 3'd1;
    localparam logic [2:0] MOP_LDA = 3'd2;
    localparam logic [2:0] MOP_STA = 3'd3;
    localparam logic [2:0] MOP_BUN = 3'd4;
    localparam logic [2:0] MOP_BSA = 3'd5;
    localparam logic [2:0] MOP_ISZ = 3'd6;
    localparam logic [2:0] MOP_REG = 3'd7;

    // Decoded register-reference / IO instruction.
    typedef struct packed {
        op_code_e op;
        skip_e    skip;
        logic     hlt;
        logic     ion;
        logic     iof;
    } regref_t;

    // Keep only the most significant set bit, so multi-bit words run one micro-op.
    function automatic logic [11:0] msb_onehot(input logic [11:0] v);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < 12; i++) begin
            if (v[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/regref_decode.sv
// Combinational priority decoder for register-reference and IO instructions.
module regref_decode
    import cpu_pkg::*;
(
    input  logic [11:0] reg_bits_i,
    input  logic        io_i,
    output regref_t     dec_o
);

    logic [11:0] sel;

    // Highest set bit wins; IO words only recognise ION/IOF.
    always_comb begin
        sel        = msb_onehot(reg_bits_i);
        dec_o.op   = OP_NOP;
        dec_o.skip = SKIP_NONE;
        dec_o.hlt  = 1'b0;
        dec_o.ion  = 1'b0;
        dec_o.iof  = 1'b0;
        if (io_i) begin
            dec_o.ion = sel[7];
            dec_o.iof = sel[6];
        end else begin
            unique case (sel)
                12'h800: dec_o.op   = OP_CLA;
                12'h400: dec_o.op   = OP_CLE;
                12'h200: dec_o.op   = OP_CMA;
                12'h100: dec_o.op   = OP_CME;
                12'h080: dec_o.op   = OP_CIR;
                12'h040: dec_o.op   = OP_CIL;
                12'h020: dec_o.op   = OP_INC;
                12'h010: dec_o.skip = SKIP_SPA;
                12'h008: dec_o.skip = SKIP_SNA;
                12'h004: dec_o.skip = SKIP_SZA;
                12'h002: dec_o.skip = SKIP_SZE;
                12'h001: dec_o.hlt  = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Instruction sequencer: fetch/indirect/execute/interrupt control for the
// accumulator CPU, with a req/ack memory port and datapath op strobes.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 12,
    parameter int INT_EN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_run,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [AWIDTH-1:0] o_mem_addr,
    output logic [DWIDTH-1:0] o_mem_wdata,
    input  logic              i_mem_ack,
    input  logic [DWIDTH-1:0] i_mem_rdata,
    input  logic [DWIDTH-1:0] i_ac,
    input  logic              i_e,
    input  logic              i_irq,
    output logic              o_op_valid,
    output logic [3:0]        o_op_code,
    output logic [DWIDTH-1:0] o_operand,
    output logic [AWIDTH-1:0] o_pc,
    output logic [DWIDTH-1:0] o_ir,
    output logic              o_ien,
    output logic              o_halted,
    output logic [3:0]        o_state
);

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] pc_q, pc_d;
    logic [AWIDTH-1:0] ar_q, ar_d;
    logic [DWIDTH-1:0] ir_q, ir_d;
    logic              ien_q, ien_d;
    logic [DWIDTH-1:0] operand_q, operand_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;

    logic              ind_bit;
    logic [2:0]        opc;
    logic [AWIDTH-1:0] ir_addr;
    logic [AWIDTH-1:0] rd_addr;
    logic [AWIDTH-1:0] tgt;
    logic [DWIDTH-1:0] pc_ext;
    logic              mem_done;
    logic              dispatch;
    logic              instr_end;
    logic              skip_hit;
    regref_t           rr;

    assign ind_bit  = ir_q[DWIDTH-1];
    assign opc      = ir_q[DWIDTH-2:DWIDTH-4];
    assign ir_addr  = ir_q[AWIDTH-1:0];
    assign rd_addr  = i_mem_rdata[AWIDTH-1:0];
    assign pc_ext   = {{(DWIDTH-AWIDTH){1'b0}}, pc_q};
    assign mem_done = o_mem_req && i_mem_ack;

    regref_decode u_regref_decode (
        .reg_bits_i (ir_q[11:0]),
        .io_i       (ind_bit),
        .dec_o      (rr)
    );

    // Skip condition for the decoded register-reference test.
    always_comb begin
        skip_hit = 1'b0;
        unique case (rr.skip)
            SKIP_SPA: skip_hit = ~i_ac[DWIDTH-1];
            SKIP_SNA: skip_hit = i_ac[DWIDTH-1];
            SKIP_SZA: skip_hit = (i_ac == '0);
            SKIP_SZE: skip_hit = ~i_e;
            default:  skip_hit = 1'b0;
        endcase
    end

    // Next-state and architectural register updates.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ar_d      = ar_q;
        ir_d      = ir_q;
        ien_d     = ien_q;
        operand_d = operand_q;
        wdata_d   = wdata_q;
        dispatch  = 1'b0;
        instr_end = 1'b0;
        tgt       = ir_addr;

        unique case (state_q)
            ST_IDLE: begin
                if (i_run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_done) begin
                    ir_d    = i_mem_rdata;
                    pc_d    = pc_q + AWIDTH'(1);
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                ar_d = ir_addr;
                if (opc == MOP_REG) begin
                    state_d = ST_EXEC_REG;
                end else if (ind_bit) begin
                    state_d = ST_INDIRECT;
                end else begin
                    dispatch = 1'b1;
                    tgt      = ir_addr;
                end
            end
            ST_INDIRECT: begin
                if (mem_done) begin
                    ar_d     = rd_addr;
                    dispatch = 1'b1;
                    tgt      = rd_addr;
                end
            end
            ST_EXEC_RD: begin
                if (mem_done) begin
                    if (opc == MOP_ISZ) begin
                        wdata_d = i_mem_rdata + DWIDTH'(1);
                        state_d = ST_EXEC_WR;
                    end else begin
                        operand_d = i_mem_rdata;
                        state_d   = ST_EXEC_OP;
                    end
                end
            end
            ST_EXEC_OP: begin
                instr_end = 1'b1;
            end
            ST_EXEC_WR: begin
                if (mem_done) begin
                    if (opc == MOP_BSA) begin
                        pc_d = ar_q + AWIDTH'(1);
                    end else if ((opc == MOP_ISZ) && (wdata_q == '0)) begin
                        pc_d = pc_q + AWIDTH'(1);
                    end
                    instr_end = 1'b1;
                end
            end
            ST_EXEC_REG: begin
                if (ind_bit) begin
                    if (rr.ion) ien_d = 1'b1;
                    if (rr.iof) ien_d = 1'b0;
                    instr_end = 1'b1;
                end else if (rr.hlt) begin
                    state_d = ST_HALT;
                end else begin
                    if (skip_hit) pc_d = pc_q + AWIDTH'(1);
                    instr_end = 1'b1;
                end
            end
            ST_INTR: begin
                if (mem_done) begin
                    pc_d    = AWIDTH'(1);
                    ien_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: begin
                if (!i_run) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Memory-reference dispatch once the effective address is known.
        if (dispatch) begin
            unique case (opc)
                MOP_AND, MOP_ADD, MOP_LDA, MOP_ISZ: state_d = ST_EXEC_RD;
                MOP_STA: begin
                    wdata_d = i_ac;
                    state_d = ST_EXEC_WR;
                end
                MOP_BSA: begin
                    wdata_d = pc_ext;
                    state_d = ST_EXEC_WR;
                end
                MOP_BUN: begin
                    pc_d      = tgt;
                    instr_end = 1'b1;
                end
                default: state_d = ST_EXEC_REG;
            endcase
        end

        if (INT_EN == 0) ien_d = 1'b0;

        // The interrupt request is only looked at on the instruction end edge.
        if (instr_end) begin
            state_d = ((INT_EN != 0) && ien_d && i_irq) ? ST_INTR : ST_FETCH;
        end
    end

    // State and architectural registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ar_q      <= '0;
            ir_q      <= '0;
            ien_q     <= 1'b0;
            operand_q <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ar_q      <= ar_d;
            ir_q      <= ir_d;
            ien_q     <= ien_d;
            operand_q <= operand_d;
            wdata_q   <= wdata_d;
        end
    end

    // Memory port and op strobe, decoded from registered state only.
    always_comb begin
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_op_valid  = 1'b0;
        o_op_code   = OP_NOP;
        unique case (state_q)
            ST_FETCH: begin
                o_mem_req  = 1'b1;
                o_mem_addr = pc_q;
            end
            ST_INDIRECT, ST_EXEC_RD: begin
                o_mem_req  = 1'b1;
                o_mem_addr = ar_q;
            end
            ST_EXEC_WR: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = ar_q;
                o_mem_wdata = wdata_q;
            end
            ST_INTR: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = '0;
                o_mem_wdata = pc_ext;
            end
            ST_EXEC_OP: begin
                o_op_valid = 1'b1;
                if (opc == MOP_AND)      o_op_code = OP_AND;
                else if (opc == MOP_ADD) o_op_code = OP_ADD;
                else                     o_op_code = OP_LDA;
            end
            ST_EXEC_REG: begin
                if (!ind_bit && (rr.op != OP_NOP)) begin
                    o_op_valid = 1'b1;
                    o_op_code  = rr.op;
                end
            end
            default: ;
        endcase
    end

    assign o_operand = operand_q;
    assign o_pc      = pc_q;
    assign o_ir      = ir_q;
    assign o_ien     = ien_q;
    assign o_halted  = (state_q == ST_HALT);
    assign o_state   = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer with a wait-state memory model.
module tb_cpu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_run;
    logic        o_mem_req, o_mem_we;
    logic [11:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [15:0] i_ac;
    logic        i_e;
    logic        i_irq;
    logic        o_op_valid;
    logic [3:0]  o_op_code;
    logic [15:0] o_operand;
    logic [11:0] o_pc;
    logic [15:0] o_ir;
    logic        o_ien, o_halted;
    logic [3:0]  o_state;

    logic [15:0] mem [0:4095];
    int          delay = 0;
    int          wcnt  = 0;

    typedef struct {
        logic [11:0] addr;
        logic        we;
        logic [15:0] wdata;
        int          len;
    } txn_t;
    typedef struct {
        logic [3:0]  code;
        logic [15:0] operand;
        int          cyc;
    } opl_t;

    txn_t txq[$];
    opl_t opq[$];
    int   cur_len;
    int   cyc;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cpu_sequencer #(.DWIDTH(16), .AWIDTH(12), .INT_EN(1)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_run       (i_run),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata),
        .i_ac        (i_ac),
        .i_e         (i_e),
        .i_irq       (i_irq),
        .o_op_valid  (o_op_valid),
        .o_op_code   (o_op_code),
        .o_operand   (o_operand),
        .o_pc        (o_pc),
        .o_ir        (o_ir),
        .o_ien       (o_ien),
        .o_halted    (o_halted),
        .o_state     (o_state)
    );

    // Memory acknowledges after 'delay' extra wait cycles.
    assign mem_ack   = o_mem_req && (wcnt >= delay);
    assign mem_rdata = mem[o_mem_addr];

    always @(posedge clk) begin
        if (!o_mem_req || mem_ack) wcnt <= 0;
        else                       wcnt <= wcnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: sample at the falling edge, log ops and completed transactions.
    task automatic tick();
        txn_t t;
        opl_t o;
        @(negedge clk);
        cyc++;
        if (reset_n) begin
            if (o_op_valid) begin
                o.code = o_op_code; o.operand = o_operand; o.cyc = cyc;
                opq.push_back(o);
            end
            if (o_mem_req) cur_len++;
            if (o_mem_req && mem_ack) begin
                t.addr = o_mem_addr; t.we = o_mem_we; t.wdata = o_mem_wdata; t.len = cur_len;
                txq.push_back(t);
                cur_len = 0;
                if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset_n = 1'b0; i_run = 1'b0; i_irq = 1'b0;
        repeat (3) tick();
        check_eq("rst_ctrl", {o_mem_req, o_mem_we, o_op_valid, o_ien, o_halted, o_op_code, o_state}, 32'h0);
        check_eq("rst_pc_ir", {o_pc, o_ir}, 32'h0);
        check_eq("rst_addr_data", {o_mem_addr, o_mem_wdata}, 32'h0);
        check_eq("rst_operand", o_operand, 32'h0);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic start_run();
        txq.delete(); opq.delete(); cur_len = 0;
        i_run = 1'b1;
        cyc = 0;
    endtask

    task automatic run_to_halt(input string tag);
        int n = 0;
        while (!o_halted && n < 300) begin
            tick();
            n++;
        end
        check_eq(tag, o_halted, 1);
    endtask

    task automatic stop_run();
        i_run = 1'b0;
        tick();
    endtask

    initial begin
        i_ac = 16'h0000; i_e = 1'b0;
        reset_n = 1'b0; i_run = 1'b0; i_irq = 1'b0;
        clear_mem();
        do_reset();

        // CLA then HLT, zero-wait memory, stepped cycle by cycle.
        delay = 0;
        mem[0] = 16'h7800; mem[1] = 16'h7001;
        start_run();
        tick();
        check_eq("cla_c1_state", o_state, 1);
        check_eq("cla_c1_req", {o_mem_req, o_mem_we, o_mem_addr}, {1'b1, 1'b0, 12'h000});
        tick();
        check_eq("cla_c2_state", o_state, 2);
        check_eq("cla_c2_pc_ir", {o_pc, o_ir}, {12'h001, 16'h7800});
        check_eq("cla_c2_noreq", o_mem_req, 0);
        tick();
        check_eq("cla_c3_op", {o_op_valid, o_op_code}, {1'b1, 4'd4});
        check_eq("cla_c3_pc", o_pc, 12'h001);
        run_to_halt("cla_halt");
        check_eq("cla_end_pc", o_pc, 12'h002);
        check_eq("cla_opcount", opq.size(), 1);
        stop_run();
        check_eq("cla_idle", o_state, 0);

        // Direct LDA with two wait states per access.
        do_reset(); clear_mem();
        delay = 2;
        mem[0] = 16'h2010; mem[1] = 16'h7001; mem[12'h010] = 16'h1234;
        start_run();
        run_to_halt("lda_halt");
        check_eq("lda_op", {opq[0].code, opq[0].operand}, {4'd3, 16'h1234});
        check_eq("lda_op_cyc", opq[0].cyc, 8);
        check_eq("lda_rd_addr", txq[1].addr, 12'h010);
        check_eq("lda_len0", txq[0].len, 3);
        check_eq("lda_len1", txq[1].len, 3);
        stop_run();

        // Indirect LDA, zero wait.
        do_reset(); clear_mem();
        delay = 0;
        mem[0] = 16'hA020; mem[1] = 16'h7001; mem[12'h020] = 16'h0030; mem[12'h030] = 16'h5555;
        start_run();
        run_to_halt("ind_halt");
        check_eq("ind_txcount", txq.size(), 4);
        check_eq("ind_order", {txq[0].addr, txq[1].addr, txq[2].addr}, {12'h000, 12'h020, 12'h030});
        check_eq("ind_op", {opq[0].code, opq[0].operand}, {4'd3, 16'h5555});
        check_eq("ind_op_cyc", opq[0].cyc, 5);
        stop_run();

        // ISZ wrapping to zero skips; ISZ of 5 does not.
        do_reset(); clear_mem();
        mem[0] = 16'h6040; mem[1] = 16'h7001; mem[2] = 16'h6041; mem[3] = 16'h7001;
        mem[12'h040] = 16'hFFFF; mem[12'h041] = 16'h0005;
        start_run();
        run_to_halt("isz_halt");
        check_eq("isz_wr", {txq[2].we, txq[2].addr, txq[2].wdata}, {1'b1, 12'h040, 16'h0000});
        check_eq("isz_next_fetch", txq[3].addr, 12'h002);
        check_eq("isz_mem41", mem[12'h041], 16'h0006);
        check_eq("isz_end_pc", o_pc, 12'h004);
        check_eq("isz_txcount", txq.size(), 7);
        stop_run();

        // BUN, STA, BSA, SZA (no skip), SNA (skip), CLA+INC priority.
        do_reset(); clear_mem();
        i_ac = 16'hBEEF;
        mem[0] = 16'h4005; mem[5] = 16'h3050; mem[6] = 16'h5060;
        mem[12'h061] = 16'h7004; mem[12'h062] = 16'h7008; mem[12'h063] = 16'h7001;
        mem[12'h064] = 16'h7820; mem[12'h065] = 16'h7001;
        start_run();
        run_to_halt("mix_halt");
        check_eq("bun_fetch", txq[1].addr, 12'h005);
        check_eq("sta_mem", mem[12'h050], 16'hBEEF);
        check_eq("bsa_mem", mem[12'h060], 16'h0007);
        check_eq("mix_end_pc", o_pc, 12'h066);
        check_eq("prio_ops", {opq.size() == 1, opq[0].code}, {1'b1, 4'd4});
        stop_run();
        i_ac = 16'h0000;

        // ION with a pending request: interrupt saves return address 1, then HLT at 1.
        do_reset(); clear_mem();
        mem[0] = 16'hF080; mem[1] = 16'h7001;
        i_irq = 1'b1;
        start_run();
        run_to_halt("intr_halt");
        check_eq("intr_wr", {txq[1].we, txq[1].addr, txq[1].wdata}, {1'b1, 12'h000, 16'h0001});
        check_eq("intr_fetch1", txq[2].addr, 12'h001);
        check_eq("intr_ien", o_ien, 0);
        check_eq("intr_end_pc", o_pc, 12'h002);
        check_eq("intr_mem0", mem[0], 16'h0001);
        stop_run();
        i_irq = 1'b0;

        // Reset during a fetch wait state, then restart from address 0.
        delay = 5;
        mem[0] = 16'h7001;
        start_run();
        tick(); tick();
        check_eq("rw_req_wait", {o_mem_req, o_state}, {1'b1, 4'd1});
        reset_n = 1'b0;
        #1;
        check_eq("rw_req_drop", o_mem_req, 0);
        check_eq("rw_outputs", {o_state, o_halted, o_ien, o_op_valid}, 32'h0);
        check_eq("rw_ir_pc", {o_pc, o_ir}, 32'h0);
        i_run = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        delay = 0;
        tick();
        start_run();
        run_to_halt("rw_halt");
        check_eq("rw_first_fetch", {txq[0].we, txq[0].addr}, {1'b0, 12'h000});
        check_eq("rw_end_pc", o_pc, 12'h001);
        stop_run();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
